// File: rtl/seq_mul_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) engine.
// One iteration per clock for WIDTH clocks, then a sign-fixup cycle and a one-cycle done pulse.
module seq_mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             op_div,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0]    count;
   logic                op_div_q;
   logic                sign_a;
   logic                sign_b;
   logic [WIDTH-1:0]    a_raw;
   // Booth accumulator / divide remainder; one guard bit so A +/- M never overflows
   logic signed [WIDTH:0] acc;
   logic [WIDTH-1:0]    q_reg;
   logic [WIDTH-1:0]    m_reg;
   logic                q_m1;

   logic signed [WIDTH:0] m_ext;
   logic signed [WIDTH:0] booth_sum;
   logic [WIDTH:0]        shifted;
   logic [WIDTH:0]        trial;

   function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                    input logic neg);
      return neg ? ((~v) + WIDTH'(1)) : v;
   endfunction

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      return cond_negate(v, v[WIDTH-1]);
   endfunction

   // State register
   always_ff @(posedge clock) begin
      if (clear) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         S_IDLE: if (start) state_nxt = S_RUN;
         S_RUN: begin
            busy = 1'b1;
            if (count == CNT_W'(WIDTH - 1)) state_nxt = S_FIX;
         end
         S_FIX: begin
            busy      = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // One iteration of either algorithm, evaluated from the current registers
   always_comb begin
      m_ext     = $signed({m_reg[WIDTH-1], m_reg});
      booth_sum = acc;
      case ({q_reg[0], q_m1})
         2'b01:   booth_sum = acc + m_ext;
         2'b10:   booth_sum = acc - m_ext;
         default: booth_sum = acc;
      endcase
      shifted = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
      trial   = shifted - {1'b0, m_reg};
   end

   // Iteration datapath: operand latch in IDLE, shift/add in RUN
   always_ff @(posedge clock) begin
      if (state == S_IDLE && start) begin
         op_div_q <= op_div;
         a_raw    <= operand_a;
         sign_a   <= operand_a[WIDTH-1];
         sign_b   <= operand_b[WIDTH-1];
         acc      <= '0;
         q_m1     <= 1'b0;
         if (op_div) begin
            q_reg <= magnitude(operand_a);
            m_reg <= magnitude(operand_b);
         end else begin
            q_reg <= operand_b;
            m_reg <= operand_a;
         end
      end else if (state == S_RUN) begin
         if (op_div_q) begin
            // Negative trial difference means the divisor did not fit: restore
            if (trial[WIDTH]) begin
               acc   <= $signed(shifted);
               q_reg <= {q_reg[WIDTH-2:0], 1'b0};
            end else begin
               acc   <= $signed(trial);
               q_reg <= {q_reg[WIDTH-2:0], 1'b1};
            end
         end else begin
            acc   <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q_reg <= {booth_sum[0], q_reg[WIDTH-1:1]};
            q_m1  <= q_reg[0];
         end
      end
   end

   // Control and result registers
   always_ff @(posedge clock) begin
      if (clear) begin
         count       <= '0;
         done        <= 1'b0;
         result_hi   <= '0;
         result_lo   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= (state == S_DONE);
         if (state == S_IDLE && start) begin
            count <= '0;
         end else if (state == S_RUN) begin
            count <= count + 1'b1;
         end else if (state == S_FIX) begin
            if (!op_div_q) begin
               result_hi   <= acc[WIDTH-1:0];
               result_lo   <= q_reg;
               div_by_zero <= 1'b0;
            end else if (m_reg == '0) begin
               result_hi   <= a_raw;
               result_lo   <= '1;
               div_by_zero <= 1'b1;
            end else begin
               result_hi   <= cond_negate(acc[WIDTH-1:0], sign_a);
               result_lo   <= cond_negate(q_reg, sign_a ^ sign_b);
               div_by_zero <= 1'b0;
            end
         end
      end
   end

endmodule
